fir_cfg_master: RTL
===================

Name: fir_cfg_master

Overview:
- AXI-Lite initiator and sequencer that configures and launches the fir accelerator.
- On a start pulse it writes Tape_Num tap coefficients and data_length, then writes ap_start.
- It then polls ap_ctrl until ap_done is set and reports completion.
- Sits between the host-side control logic and the fir AXI-Lite slave port.

Parameters:
pADDR_WIDTH, 12, AXI-Lite address width
pDATA_WIDTH, 32, AXI-Lite data width
Tape_Num, 11, number of coefficients written (1..16)
pPOLL_GAP, 4, idle cycles between consecutive ap_ctrl polls (>=0)

Ports:
axis_clk  in  1  clock
axis_rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle request to run a configuration sequence
cfg_len  in  32  data_length value; sampled on accepted cfg_start
coef_idx  out  4  index of coefficient being fetched
coef_data  in  pDATA_WIDTH  coefficient at coef_idx; combinational source
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when ap_done is observed
err  out  1  sticky readback mismatch; cleared on next accepted cfg_start
awvalid  out  1  write address valid
awready  in  1  write address ready
awaddr  out  pADDR_WIDTH  write address
wvalid  out  1  write data valid
wready  in  1  write data ready
wdata  out  pDATA_WIDTH  write data
arvalid  out  1  read address valid
arready  in  1  read address ready
araddr  out  pADDR_WIDTH  read address
rvalid  in  1  read data valid
rready  out  1  read data ready
rdata  in  pDATA_WIDTH  read data

Behaviour:

Clock and reset:
- Single clock domain axis_clk.
- axis_rst_n is asynchronous, active-low.
- Reset values: all valids, rready, busy, done and err are 0. awaddr, araddr, wdata and coef_idx are 0. State is IDLE.
- Reset mid-transaction drops all valids immediately. No transaction is resumed after reset.

Address map:
- 0x00: ap_ctrl. bit0 = ap_start, bit1 = ap_done, bit2 = ap_idle.
- 0x10: data_length.
- 0x20 + 4*i: coefficient i.

Write handshake:
- awvalid and wvalid rise together. awaddr and wdata are held stable.
- Each valid stays high until its own handshake (valid & ready at posedge), then deasserts independently.
- A write completes once both handshakes have occurred, in the same cycle or in different cycles.
- The next write's valids may assert in the following cycle. Minimum is 1 cycle per write.

Read handshake:
- arvalid is held with araddr until arready.
- rready is asserted only in the data phase, and held until rvalid.
- rdata is captured on rvalid & rready. Minimum is 2 cycles per read.

State machine:
- IDLE: wait for cfg_start.
- WR_COEF: write coefficients i = 0..Tape_Num-1. coef_idx = i; wdata = coef_data. coef_data is captured when valids first rise.
- WR_LEN: write the latched cfg_len to 0x10.
- RD_VERIFY: present only when FIR_CFG_READBACK_EN is defined. See Optional Feature.
- WR_START: write 0x00 with wdata = 0x1.
- POLL_RD: read 0x00. If rdata[1] = 1, go to DONE. Otherwise go to POLL_WAIT.
- POLL_WAIT: count pPOLL_GAP cycles, then return to POLL_RD. With pPOLL_GAP = 0, go directly to POLL_RD.
- DONE: done = 1 for one cycle, then IDLE.

Control outputs and boundaries:
- busy = 1 in every state except IDLE.
- cfg_start while busy is ignored; no queueing.
- A cfg_start in the same cycle as DONE is ignored. A cfg_start in the cycle after DONE is accepted.
- coef_idx wraps to 0 on leaving WR_COEF.
- Coefficient index arithmetic is modulo 16. awaddr is computed as 0x20 + (i << 2), truncated to pADDR_WIDTH.

Optional Feature:
FIR_CFG_READBACK_EN
- Defined: after WR_LEN, read each 0x20 + 4*i and compare with coef_data at coef_idx = i.
- Any mismatch sets err. The sequence continues to WR_START regardless.
- Undefined: WR_LEN goes directly to WR_START. err is tied to 0. The AR/R channels are used only for polling.

Test Plan:
1. Always-ready slave, coefficients i+1, cfg_len = 600 -> 11 writes to 0x20..0x48 with data 1..11 on consecutive cycles; then 0x10 <= 600; then 0x00 <= 1; busy high throughout.
2. Slave asserts wready 3 cycles before awready -> wvalid drops after its handshake; awvalid stays held; next write starts only after the AW handshake; awaddr/wdata stable while valid.
3. ap_ctrl reads return 0x4, 0x4, then 0x2 with pPOLL_GAP = 4 -> three ARs spaced ≥4 idle cycles apart; done pulses exactly once; busy falls with return to IDLE.
4. cfg_start pulsed during POLL_WAIT -> ignored; no extra writes; cfg_len latch unchanged.
5. axis_rst_n low while awvalid is high in WR_COEF -> all valids 0 asynchronously; after release, cfg_start restarts from coefficient 0.
6. With FIR_CFG_READBACK_EN, slave returns coefficient 5 corrupted -> err = 1 after that read; 0x00 <= 1 still issued; err cleared on next accepted cfg_start.

Source files
------------

// File: rtl/fir_cfg_master.sv
// AXI-Lite initiator that loads FIR taps and data_length, launches the core and polls ap_done.
// Define FIR_CFG_READBACK_EN to read every coefficient back and flag mismatches on err.
module fir_cfg_master #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int pPOLL_GAP   = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cfg_start,
  input  logic [31:0]            cfg_len,
  output logic [3:0]             coef_idx,
  input  logic [pDATA_WIDTH-1:0] coef_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rdata
);

  typedef enum logic [2:0] {
    IDLE, WR_COEF, WR_LEN, WR_START, POLL_RD, POLL_WAIT, DONE
`ifdef FIR_CFG_READBACK_EN
    , RD_VERIFY
`endif
  } state_t;

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(32'h10);
  localparam logic [15:0]            GAP_LAST  = 16'((pPOLL_GAP > 0) ? (pPOLL_GAP - 1) : 0);

  state_t      state;
  logic [31:0] len_q;
  logic [4:0]  cnt;
  logic [15:0] gap_cnt;
  logic        wr_idle;
  logic        wr_fire;
  logic        rd_fire;

  function automatic logic [pADDR_WIDTH-1:0] coef_addr(input logic [3:0] i);
    return pADDR_WIDTH'(32'h20 + {26'd0, i, 2'b00});
  endfunction

  // A write retires once each channel has handshaken, in whichever order the slave chooses
  assign wr_idle = !awvalid && !wvalid;
  assign wr_fire = (awvalid || wvalid) && (!awvalid || awready) && (!wvalid || wready);
  assign rd_fire = rready && rvalid;

`ifdef FIR_CFG_READBACK_EN
  logic err_q;
  assign err = err_q;
`else
  logic unused_rdata;
  assign err = 1'b0;
  assign unused_rdata = ^{rdata[pDATA_WIDTH-1:2], rdata[0]};
`endif

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state    <= IDLE;
      len_q    <= '0;
      cnt      <= '0;
      gap_cnt  <= '0;
      coef_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      awvalid  <= 1'b0;
      awaddr   <= '0;
      wvalid   <= 1'b0;
      wdata    <= '0;
      arvalid  <= 1'b0;
      araddr   <= '0;
      rready   <= 1'b0;
`ifdef FIR_CFG_READBACK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (awvalid && awready) awvalid <= 1'b0;
      if (wvalid && wready) wvalid <= 1'b0;
      if (arvalid && arready) begin
        arvalid <= 1'b0;
        rready  <= 1'b1;
      end
      if (rd_fire) rready <= 1'b0;

      case (state)
        IDLE: begin
          if (cfg_start) begin
            len_q    <= cfg_len;
            coef_idx <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= WR_COEF;
`ifdef FIR_CFG_READBACK_EN
            err_q    <= 1'b0;
`endif
          end
        end

        // coef_idx runs one ahead so the next tap is already on coef_data when a write retires
        WR_COEF: begin
          if (wr_idle || wr_fire) begin
            if (cnt == 5'(Tape_Num)) begin
              coef_idx <= '0;
              state    <= WR_LEN;
            end else begin
              awvalid  <= 1'b1;
              wvalid   <= 1'b1;
              awaddr   <= coef_addr(coef_idx);
              wdata    <= coef_data;
              coef_idx <= coef_idx + 4'd1;
              cnt      <= cnt + 5'd1;
            end
          end
        end

        WR_LEN: begin
          if (wr_idle) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awaddr  <= ADDR_LEN;
            wdata   <= pDATA_WIDTH'(len_q);
          end else if (wr_fire) begin
`ifdef FIR_CFG_READBACK_EN
            cnt   <= '0;
            state <= RD_VERIFY;
`else
            state <= WR_START;
`endif
          end
        end

`ifdef FIR_CFG_READBACK_EN
        RD_VERIFY: begin
          if (!arvalid && !rready) begin
            arvalid <= 1'b1;
            araddr  <= coef_addr(coef_idx);
          end else if (rd_fire) begin
            if (rdata != coef_data) err_q <= 1'b1;
            if (cnt == 5'(Tape_Num - 1)) begin
              coef_idx <= '0;
              state    <= WR_START;
            end else begin
              coef_idx <= coef_idx + 4'd1;
              cnt      <= cnt + 5'd1;
            end
          end
        end
`endif

        WR_START: begin
          if (wr_idle) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awaddr  <= ADDR_CTRL;
            wdata   <= pDATA_WIDTH'(1);
          end else if (wr_fire) begin
            state <= POLL_RD;
          end
        end

        POLL_RD: begin
          if (!arvalid && !rready) begin
            arvalid <= 1'b1;
            araddr  <= ADDR_CTRL;
          end else if (rd_fire) begin
            if (rdata[1]) begin
              done  <= 1'b1;
              state <= DONE;
            end else if (pPOLL_GAP == 0) begin
              state <= POLL_RD;
            end else begin
              gap_cnt <= '0;
              state   <= POLL_WAIT;
            end
          end
        end

        POLL_WAIT: begin
          if (gap_cnt == GAP_LAST) state <= POLL_RD;
          else gap_cnt <= gap_cnt + 16'd1;
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
